rn_axis_pkt_checker: RTL and testbench
======================================

Name: rn_axis_pkt_checker

Overview:
- Consumes the AXI-stream packet stream produced by the simulation stimulus driver, ahead of the RecoNIC datapath under test.
- Applies a programmable tready backpressure pattern.
- Per packet: checks tkeep legality and that the accumulated byte count matches tuser_size.
- Exposes saturating packet, beat, byte and error counters plus a per-packet completion pulse, for bench scoreboarding.

Parameters:
AXIS_DATA_WIDTH, 512, stream data width in bits
AXIS_KEEP_WIDTH, 64, tkeep width (AXIS_DATA_WIDTH/8)
USER_SIZE_WIDTH, 16, width of the tuser_size packet-length field
CNT_WIDTH, 32, width of every statistics counter

Ports:
axis_clk  in  1  single clock
axis_rstn  in  1  asynchronous active-low reset
s_axis_tdata  in  AXIS_DATA_WIDTH  stream data (not checked, not stored)
s_axis_tkeep  in  AXIS_KEEP_WIDTH  byte enables
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last beat of packet
s_axis_tuser_size  in  USER_SIZE_WIDTH  packet length in bytes, same on every beat
s_axis_tready  out  1  registered ready
bp_enable  in  1  1: tready follows bp_pattern; 0: tready=1
bp_pattern  in  32  rotating ready mask, bit0 used first
stat_clear  in  1  synchronous clear of counters and sticky flags
pkt_cnt  out  CNT_WIDTH  packets completed
beat_cnt  out  CNT_WIDTH  beats accepted
byte_cnt  out  CNT_WIDTH  bytes accepted (popcount of tkeep)
err_size_cnt  out  CNT_WIDTH  packets with a size error
err_keep_cnt  out  CNT_WIDTH  packets with a tkeep error
pkt_done  out  1  one-cycle pulse per completed packet
pkt_len  out  USER_SIZE_WIDTH  byte count of the last completed packet
pkt_err  out  1  error status of the last completed packet, valid with pkt_done
err_sticky  out  1  set on any packet error until stat_clear

Behaviour:
- Reset (async assert, sync release): all outputs 0, including s_axis_tready. FSM goes to IDLE, pattern pointer to 0, accumulators to 0.
- Acceptance: a beat is accepted when tvalid && tready on a rising edge. Only accepted beats are processed.
- Backpressure:
  - 5-bit pointer ptr increments (mod 32) every cycle out of reset.
  - s_axis_tready is registered: next value is bp_pattern[ptr] when bp_enable=1, else 1.
  - First post-reset cycle: tready=0.
- FSM, IDLE:
  - Accepted beat: latch tuser_size to size_q and set acc = popcount(tkeep).
  - If tlast=0, go to IN_PKT.
  - If tlast=1, finalise in the same cycle (single-beat packet) and stay in IDLE.
- FSM, IN_PKT:
  - Accepted beat adds popcount(tkeep) to acc (USER_SIZE_WIDTH+1 bits, saturating).
  - tlast goes to IDLE and finalises.
- tkeep rules, per packet, sticky until finalised:
  - Non-last beat must be all ones.
  - Last beat must be non-zero and contiguous from bit0 (tkeep & (tkeep+1) == 0).
  - Any violation sets keep_err.
- Size rules, sticky until finalised:
  - tuser_size on any non-first beat differing from size_q sets size_err.
  - At finalise, acc+beat bytes != size_q sets size_err.
- Finalise (the tlast beat's cycle): one cycle later pkt_done=1, pkt_len = final byte count, pkt_err = size_err|keep_err.
  - pkt_cnt +1.
  - err_size_cnt +1 if size_err; err_keep_cnt +1 if keep_err. Both increment if both errors occur.
  - err_sticky set if any error.
  - Error bits clear for the next packet.
- Counters:
  - beat_cnt +1 and byte_cnt +popcount per accepted beat, registered (one-cycle latency).
  - All counters saturate at all-ones; they never wrap.
- stat_clear:
  - Zeroes all counters and err_sticky next cycle.
  - Clear wins over a same-cycle increment.
  - Does not affect the FSM, acc, ptr, pkt_len or an in-flight packet's error bits.
- tvalid while tready=0: ignored; the upstream must hold the beat.
- Reset mid-packet: the partial packet is discarded; no pkt_done is produced.

Test Plan:
- bp_enable=0; one 64-byte packet (1 beat, tkeep all ones, tuser_size=64, tlast) -> pkt_done one cycle later, pkt_len=64, pkt_err=0, pkt_cnt=1, beat_cnt=1, byte_cnt=64.
- bp_enable=0; 100-byte packet (beat0 all ones; beat1 tkeep=0x0000_000F_FFFF_FFFF, tlast, tuser_size=100) -> pkt_len=100, pkt_err=0, beat_cnt=2, byte_cnt=100.
- bp_enable=0; 100-byte payload sent with tuser_size=96 -> pkt_err=1, err_size_cnt=1, err_sticky=1; next clean packet -> pkt_err=0, err_size_cnt stays 1.
- bp_enable=0; last beat tkeep=0x5 -> keep error: err_keep_cnt=1. Non-last beat with tkeep≠all ones -> err_keep_cnt +1.
- bp_enable=1, bp_pattern=0x5555_5555; 10 back-to-back 128-byte packets held by upstream -> tready alternates 0/1; pkt_cnt=10, beat_cnt=20, byte_cnt=1280, no errors.
- stat_clear asserted in the same cycle as a tlast beat -> all counters 0 afterwards; pkt_done still pulses. Reset asserted mid-packet -> all outputs 0 immediately, no pkt_done.

Source files
------------

// File: rtl/rn_axis_pkt_checker.sv
// AXI-stream packet sink: programmable tready backpressure, per-packet tkeep/size
// checking and saturating statistics for bench scoreboarding.
//
// state  | meaning
// IDLE   | waiting for the first beat of a packet
// IN_PKT | first beat accepted, accumulating until tlast
module rn_axis_pkt_checker #(
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int AXIS_KEEP_WIDTH = 64,
   parameter int USER_SIZE_WIDTH = 16,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                       axis_clk,
   input  logic                       axis_rstn,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                       s_axis_tvalid,
   input  logic                       s_axis_tlast,
   input  logic [USER_SIZE_WIDTH-1:0] s_axis_tuser_size,
   output logic                       s_axis_tready,
   input  logic                       bp_enable,
   input  logic [31:0]                bp_pattern,
   input  logic                       stat_clear,
   output logic [CNT_WIDTH-1:0]       pkt_cnt,
   output logic [CNT_WIDTH-1:0]       beat_cnt,
   output logic [CNT_WIDTH-1:0]       byte_cnt,
   output logic [CNT_WIDTH-1:0]       err_size_cnt,
   output logic [CNT_WIDTH-1:0]       err_keep_cnt,
   output logic                       pkt_done,
   output logic [USER_SIZE_WIDTH-1:0] pkt_len,
   output logic                       pkt_err,
   output logic                       err_sticky
);

   localparam int POP_W = $clog2(AXIS_KEEP_WIDTH + 1);
   localparam int ACC_W = USER_SIZE_WIDTH + 1;

   typedef enum logic {IDLE, IN_PKT} state_t;

   state_t                     state_q;
   logic [4:0]                 ptr_q;
   logic                       tready_q;
   logic [USER_SIZE_WIDTH-1:0] size_q;
   logic [ACC_W-1:0]           acc_q;
   logic                       size_err_q;
   logic                       keep_err_q;
   logic [CNT_WIDTH-1:0]       pkt_cnt_q;
   logic [CNT_WIDTH-1:0]       beat_cnt_q;
   logic [CNT_WIDTH-1:0]       byte_cnt_q;
   logic [CNT_WIDTH-1:0]       err_size_cnt_q;
   logic [CNT_WIDTH-1:0]       err_keep_cnt_q;
   logic                       pkt_done_q;
   logic [USER_SIZE_WIDTH-1:0] pkt_len_q;
   logic                       pkt_err_q;
   logic                       err_sticky_q;

   logic                       accept;
   logic                       first_beat;
   logic [POP_W-1:0]           beat_bytes;
   logic                       keep_full;
   logic                       keep_contig;
   logic                       keep_bad;
   logic [ACC_W:0]             acc_sum;
   logic [ACC_W-1:0]           acc_d;
   logic [USER_SIZE_WIDTH-1:0] size_ref;
   logic                       size_err_d;
   logic                       keep_err_d;
   logic                       finalise;
   logic [USER_SIZE_WIDTH-1:0] pkt_len_d;
   logic                       unused_tdata;

   assign unused_tdata = ^s_axis_tdata;

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
   endfunction

   always_comb begin
      beat_bytes = '0;
      for (int i = 0; i < AXIS_KEEP_WIDTH; i++)
         beat_bytes = beat_bytes + POP_W'(s_axis_tkeep[i]);
   end

   // Error state and the byte total include the current beat so a tlast beat
   // can be finalised in the cycle it is accepted.
   always_comb begin
      accept      = s_axis_tvalid && tready_q;
      first_beat  = (state_q == IDLE);
      keep_full   = &s_axis_tkeep;
      keep_contig = (s_axis_tkeep != '0) &&
                    ((s_axis_tkeep & (s_axis_tkeep + AXIS_KEEP_WIDTH'(1))) == '0);
      keep_bad    = s_axis_tlast ? !keep_contig : !keep_full;
      acc_sum     = {1'b0, (first_beat ? '0 : acc_q)} + (ACC_W + 1)'(beat_bytes);
      acc_d       = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      size_ref    = first_beat ? s_axis_tuser_size : size_q;
      size_err_d  = (!first_beat && size_err_q) ||
                    (!first_beat && (s_axis_tuser_size != size_q)) ||
                    (s_axis_tlast && (acc_d != {1'b0, size_ref}));
      keep_err_d  = (!first_beat && keep_err_q) || keep_bad;
      finalise    = accept && s_axis_tlast;
      pkt_len_d   = acc_d[ACC_W-1] ? '1 : acc_d[USER_SIZE_WIDTH-1:0];
   end

   always_ff @(posedge axis_clk or negedge axis_rstn) begin
      if (!axis_rstn) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         tready_q       <= 1'b0;
         size_q         <= '0;
         acc_q          <= '0;
         size_err_q     <= 1'b0;
         keep_err_q     <= 1'b0;
         pkt_cnt_q      <= '0;
         beat_cnt_q     <= '0;
         byte_cnt_q     <= '0;
         err_size_cnt_q <= '0;
         err_keep_cnt_q <= '0;
         pkt_done_q     <= 1'b0;
         pkt_len_q      <= '0;
         pkt_err_q      <= 1'b0;
         err_sticky_q   <= 1'b0;
      end else begin
         ptr_q      <= ptr_q + 5'd1;
         tready_q   <= bp_enable ? bp_pattern[ptr_q] : 1'b1;
         pkt_done_q <= 1'b0;

         if (accept) begin
            acc_q <= acc_d;
            if (first_beat)
               size_q <= s_axis_tuser_size;
            if (s_axis_tlast) begin
               state_q    <= IDLE;
               size_err_q <= 1'b0;
               keep_err_q <= 1'b0;
               pkt_done_q <= 1'b1;
               pkt_len_q  <= pkt_len_d;
               pkt_err_q  <= size_err_d || keep_err_d;
            end else begin
               state_q    <= IN_PKT;
               size_err_q <= size_err_d;
               keep_err_q <= keep_err_d;
            end
         end

         if (stat_clear) begin
            pkt_cnt_q      <= '0;
            beat_cnt_q     <= '0;
            byte_cnt_q     <= '0;
            err_size_cnt_q <= '0;
            err_keep_cnt_q <= '0;
            err_sticky_q   <= 1'b0;
         end else begin
            if (accept) begin
               beat_cnt_q <= sat_add(beat_cnt_q, CNT_WIDTH'(1));
               byte_cnt_q <= sat_add(byte_cnt_q, CNT_WIDTH'(beat_bytes));
            end
            if (finalise) begin
               pkt_cnt_q <= sat_add(pkt_cnt_q, CNT_WIDTH'(1));
               if (size_err_d)
                  err_size_cnt_q <= sat_add(err_size_cnt_q, CNT_WIDTH'(1));
               if (keep_err_d)
                  err_keep_cnt_q <= sat_add(err_keep_cnt_q, CNT_WIDTH'(1));
               if (size_err_d || keep_err_d)
                  err_sticky_q <= 1'b1;
            end
         end
      end
   end

   assign s_axis_tready = tready_q;
   assign pkt_cnt       = pkt_cnt_q;
   assign beat_cnt      = beat_cnt_q;
   assign byte_cnt      = byte_cnt_q;
   assign err_size_cnt  = err_size_cnt_q;
   assign err_keep_cnt  = err_keep_cnt_q;
   assign pkt_done      = pkt_done_q;
   assign pkt_len       = pkt_len_q;
   assign pkt_err       = pkt_err_q;
   assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_rn_axis_pkt_checker.sv
// Bench for rn_axis_pkt_checker: packet-level reference model, directed and
// randomized traffic, backpressure pattern, stat_clear and mid-packet reset.
module tb_rn_axis_pkt_checker;

   logic         axis_clk = 1'b0;
   logic         axis_rstn = 1'b0;
   logic [511:0] s_axis_tdata = '0;
   logic [63:0]  s_axis_tkeep = '0;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tlast = 1'b0;
   logic [15:0]  s_axis_tuser_size = '0;
   logic         s_axis_tready;
   logic         bp_enable = 1'b0;
   logic [31:0]  bp_pattern = '0;
   logic         stat_clear = 1'b0;
   logic [31:0]  pkt_cnt, beat_cnt, byte_cnt, err_size_cnt, err_keep_cnt;
   logic         pkt_done;
   logic [15:0]  pkt_len;
   logic         pkt_err;
   logic         err_sticky;

   rn_axis_pkt_checker dut (
      .axis_clk(axis_clk), .axis_rstn(axis_rstn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
      .s_axis_tuser_size(s_axis_tuser_size), .s_axis_tready(s_axis_tready),
      .bp_enable(bp_enable), .bp_pattern(bp_pattern), .stat_clear(stat_clear),
      .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt), .byte_cnt(byte_cnt),
      .err_size_cnt(err_size_cnt), .err_keep_cnt(err_keep_cnt),
      .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_err(pkt_err),
      .err_sticky(err_sticky)
   );

   always #5 axis_clk = ~axis_clk;

   int n_pass = 0;
   int n_tot  = 0;
   int cyc    = 0;
   int rst_cyc = 0;

   // packet under construction
   logic [63:0] pk_keep[$];
   logic [15:0] pk_size[$];
   bit          clr_last = 0;

   // expected and observed completions
   logic [15:0] exp_len[$];
   bit          exp_err[$];
   int          exp_cyc[$];
   logic [15:0] obs_len[$];
   bit          obs_err[$];
   int          obs_cyc[$];

   int unsigned m_pkt = 0, m_beat = 0, m_byte = 0, m_esize = 0, m_ekeep = 0;
   bit          m_sticky = 0;

   always @(posedge axis_clk) cyc <= cyc + 1;

   always @(negedge axis_clk) begin
      if (axis_rstn && pkt_done) begin
         obs_len.push_back(pkt_len);
         obs_err.push_back(pkt_err);
         obs_cyc.push_back(cyc);
      end
   end

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (n) @(posedge axis_clk);
      #1;
   endtask

   task automatic add_beat(input logic [63:0] k, input logic [15:0] s);
      pk_keep.push_back(k);
      pk_size.push_back(s);
   endtask

   // Presents one beat and holds it until the DUT's registered tready takes it.
   task automatic send_beat(input logic [63:0] k, input logic [15:0] s, input logic last,
                            output int acc_cyc);
      int n;
      n = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tkeep = k;
      s_axis_tuser_size = s;
      s_axis_tlast = last;
      for (int i = 0; i < 16; i++) s_axis_tdata[i*32 +: 32] = $urandom;
      forever begin
         @(negedge axis_clk);
         if (s_axis_tready === 1'b1) break;
         n++;
         if (n > 300) begin
            n_tot++;
            $display("FAIL handshake_timeout tready stuck at %b, wanted 1 within 300 cycles", s_axis_tready);
            $display("%0d/%0d checks passed", n_pass, n_tot);
            $fatal(1, "handshake timeout");
         end
      end
      @(posedge axis_clk);
      #1;
      acc_cyc = cyc;
   endtask

   // Sends the queued beats as one packet and updates the packet-level model.
   task automatic send_pkt();
      int nb, pc, c;
      int unsigned bytes;
      bit kerr, serr;
      nb = pk_keep.size();
      bytes = 0; kerr = 0; serr = 0; c = 0;
      for (int i = 0; i < nb; i++) begin
         pc = $countones(pk_keep[i]);
         bytes += pc;
         if (i < nb - 1) kerr |= (pk_keep[i] != 64'hFFFF_FFFF_FFFF_FFFF);
         else kerr |= (pc == 0) || (pk_keep[i] != ((64'd1 << pc) - 64'd1));
         serr |= (pk_size[i] != pk_size[0]);
         if (i == nb - 1) stat_clear = clr_last;
         send_beat(pk_keep[i], pk_size[i], i == nb - 1, c);
         stat_clear = 1'b0;
      end
      serr |= (bytes != 32'(pk_size[0]));
      exp_len.push_back(16'(bytes));
      exp_err.push_back(serr | kerr);
      exp_cyc.push_back(c);
      m_pkt++; m_beat += nb; m_byte += bytes;
      m_esize += serr; m_ekeep += kerr; m_sticky |= serr | kerr;
      if (clr_last) begin
         m_pkt = 0; m_beat = 0; m_byte = 0; m_esize = 0; m_ekeep = 0; m_sticky = 0;
      end
      pk_keep.delete();
      pk_size.delete();
   endtask

   task automatic test_reset();
      axis_rstn = 1'b0;
      #23;
      n_tot++; if (s_axis_tready !== 1'b0) $display("FAIL reset_tready got %b want 0", s_axis_tready); else n_pass++;
      n_tot++; if (pkt_done !== 1'b0 || pkt_err !== 1'b0 || err_sticky !== 1'b0) $display("FAIL reset_flags got %b%b%b want 000", pkt_done, pkt_err, err_sticky); else n_pass++;
      n_tot++; if (pkt_len !== 16'd0) $display("FAIL reset_pkt_len got %0d want 0", pkt_len); else n_pass++;
      n_tot++; if ((pkt_cnt | beat_cnt | byte_cnt | err_size_cnt | err_keep_cnt) !== 32'd0) $display("FAIL reset_counters got %0d/%0d/%0d/%0d/%0d want 0", pkt_cnt, beat_cnt, byte_cnt, err_size_cnt, err_keep_cnt); else n_pass++;
      @(negedge axis_clk);
      axis_rstn = 1'b1;
      rst_cyc = cyc;
      #1;
      n_tot++; if (s_axis_tready !== 1'b0) $display("FAIL first_cycle_tready got %b want 0", s_axis_tready); else n_pass++;
      @(posedge axis_clk);
      #1;
      n_tot++; if (s_axis_tready !== 1'b1) $display("FAIL tready_bp_off got %b want 1", s_axis_tready); else n_pass++;
   endtask

   task automatic test_basic();
      bp_enable = 1'b0;
      idle(1);
      add_beat('1, 16'd64); send_pkt();
      add_beat('1, 16'd100); add_beat(64'h0000_000F_FFFF_FFFF, 16'd100); send_pkt();
      add_beat('1, 16'd96); add_beat(64'h0000_000F_FFFF_FFFF, 16'd96); send_pkt();
      add_beat('1, 16'd128); add_beat('1, 16'd128); send_pkt();
      add_beat(64'h5, 16'd2); send_pkt();
      add_beat(64'h7FFF_FFFF_FFFF_FFFF, 16'd64); add_beat(64'h1, 16'd64); send_pkt();
      idle(3);
      n_tot++; if (obs_len.size() != exp_len.size()) $display("FAIL basic_done_count got %0d want %0d", obs_len.size(), exp_len.size()); else n_pass++;
      for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
         n_tot++;
         if (obs_len[i] !== exp_len[i] || obs_err[i] !== exp_err[i] || obs_cyc[i] != exp_cyc[i])
            $display("FAIL basic_pkt%0d len/err/cyc got %0d/%0d/%0d want %0d/%0d/%0d", i, obs_len[i], obs_err[i], obs_cyc[i], exp_len[i], exp_err[i], exp_cyc[i]);
         else n_pass++;
      end
      obs_len.delete(); obs_err.delete(); obs_cyc.delete(); exp_len.delete(); exp_err.delete(); exp_cyc.delete();
      n_tot++; if (pkt_cnt !== m_pkt) $display("FAIL basic_pkt_cnt got %0d want %0d", pkt_cnt, m_pkt); else n_pass++;
      n_tot++; if (beat_cnt !== m_beat) $display("FAIL basic_beat_cnt got %0d want %0d", beat_cnt, m_beat); else n_pass++;
      n_tot++; if (byte_cnt !== m_byte) $display("FAIL basic_byte_cnt got %0d want %0d", byte_cnt, m_byte); else n_pass++;
      n_tot++; if (err_size_cnt !== m_esize) $display("FAIL basic_err_size_cnt got %0d want %0d", err_size_cnt, m_esize); else n_pass++;
      n_tot++; if (err_keep_cnt !== m_ekeep) $display("FAIL basic_err_keep_cnt got %0d want %0d", err_keep_cnt, m_ekeep); else n_pass++;
      n_tot++; if (err_sticky !== m_sticky) $display("FAIL basic_err_sticky got %b want %b", err_sticky, m_sticky); else n_pass++;
   endtask

   task automatic test_backpressure();
      int idx;
      logic exp_rdy;
      bp_pattern = 32'h5555_5555;
      bp_enable = 1'b1;
      idle(2);
      for (int k = 0; k < 32; k++) begin
         @(negedge axis_clk);
         idx = (cyc - rst_cyc - 1) % 32;
         exp_rdy = bp_pattern[idx];
         n_tot++; if (s_axis_tready !== exp_rdy) $display("FAIL bp_alt_tready ptr%0d got %b want %b", idx, s_axis_tready, exp_rdy); else n_pass++;
      end
      @(posedge axis_clk); #1;
      repeat (10) begin
         add_beat('1, 16'd128); add_beat('1, 16'd128); send_pkt();
      end
      idle(3);
      n_tot++; if (obs_len.size() != exp_len.size()) $display("FAIL bp_done_count got %0d want %0d", obs_len.size(), exp_len.size()); else n_pass++;
      for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
         n_tot++;
         if (obs_len[i] !== exp_len[i] || obs_err[i] !== exp_err[i] || obs_cyc[i] != exp_cyc[i])
            $display("FAIL bp_pkt%0d len/err/cyc got %0d/%0d/%0d want %0d/%0d/%0d", i, obs_len[i], obs_err[i], obs_cyc[i], exp_len[i], exp_err[i], exp_cyc[i]);
         else n_pass++;
      end
      obs_len.delete(); obs_err.delete(); obs_cyc.delete(); exp_len.delete(); exp_err.delete(); exp_cyc.delete();
      n_tot++; if (pkt_cnt !== m_pkt) $display("FAIL bp_pkt_cnt got %0d want %0d", pkt_cnt, m_pkt); else n_pass++;
      n_tot++; if (beat_cnt !== m_beat) $display("FAIL bp_beat_cnt got %0d want %0d", beat_cnt, m_beat); else n_pass++;
      n_tot++; if (byte_cnt !== m_byte) $display("FAIL bp_byte_cnt got %0d want %0d", byte_cnt, m_byte); else n_pass++;
      bp_pattern = $urandom | 32'h1;
      idle(1);
      for (int k = 0; k < 40; k++) begin
         @(negedge axis_clk);
         idx = (cyc - rst_cyc - 1) % 32;
         exp_rdy = bp_pattern[idx];
         n_tot++; if (s_axis_tready !== exp_rdy) $display("FAIL bp_rand_tready ptr%0d got %b want %b", idx, s_axis_tready, exp_rdy); else n_pass++;
      end
      @(posedge axis_clk); #1;
   endtask

   task automatic test_random();
      int nb, kind, last_pc, j;
      int unsigned total;
      logic [15:0] sz;
      bp_enable = 1'b1;
      bp_pattern = $urandom | 32'h1;
      idle(1);
      repeat (40) begin
         nb = $urandom_range(1, 4);
         kind = $urandom_range(0, 9);
         last_pc = $urandom_range(1, 64);
         total = 32'((nb - 1) * 64 + last_pc);
         sz = 16'(total);
         if (kind == 0) sz = sz + 16'($urandom_range(1, 5));
         for (int i = 0; i < nb; i++)
            add_beat((i < nb - 1) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << last_pc) - 64'd1), sz);
         if (kind == 1 && nb > 1) begin
            j = $urandom_range(1, nb - 1);
            pk_size[j] = pk_size[j] ^ 16'd1;
         end
         if (kind == 2 && nb > 1) begin
            j = $urandom_range(0, nb - 2);
            pk_keep[j][$urandom_range(0, 63)] = 1'b0;
         end
         if (kind == 3) pk_keep[nb - 1] = {$urandom, $urandom};
         send_pkt();
      end
      idle(3);
      n_tot++; if (obs_len.size() != exp_len.size()) $display("FAIL rand_done_count got %0d want %0d", obs_len.size(), exp_len.size()); else n_pass++;
      for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
         n_tot++;
         if (obs_len[i] !== exp_len[i] || obs_err[i] !== exp_err[i] || obs_cyc[i] != exp_cyc[i])
            $display("FAIL rand_pkt%0d len/err/cyc got %0d/%0d/%0d want %0d/%0d/%0d", i, obs_len[i], obs_err[i], obs_cyc[i], exp_len[i], exp_err[i], exp_cyc[i]);
         else n_pass++;
      end
      obs_len.delete(); obs_err.delete(); obs_cyc.delete(); exp_len.delete(); exp_err.delete(); exp_cyc.delete();
      n_tot++; if (pkt_cnt !== m_pkt) $display("FAIL rand_pkt_cnt got %0d want %0d", pkt_cnt, m_pkt); else n_pass++;
      n_tot++; if (beat_cnt !== m_beat) $display("FAIL rand_beat_cnt got %0d want %0d", beat_cnt, m_beat); else n_pass++;
      n_tot++; if (byte_cnt !== m_byte) $display("FAIL rand_byte_cnt got %0d want %0d", byte_cnt, m_byte); else n_pass++;
      n_tot++; if (err_size_cnt !== m_esize) $display("FAIL rand_err_size_cnt got %0d want %0d", err_size_cnt, m_esize); else n_pass++;
      n_tot++; if (err_keep_cnt !== m_ekeep) $display("FAIL rand_err_keep_cnt got %0d want %0d", err_keep_cnt, m_ekeep); else n_pass++;
      n_tot++; if (err_sticky !== m_sticky) $display("FAIL rand_err_sticky got %b want %b", err_sticky, m_sticky); else n_pass++;
   endtask

   task automatic test_stat_clear();
      bp_enable = 1'b0;
      idle(2);
      add_beat('1, 16'd64); send_pkt();
      clr_last = 1;
      add_beat('1, 16'd90); add_beat(64'hFF, 16'd90); send_pkt();
      clr_last = 0;
      idle(3);
      n_tot++; if (obs_len.size() != exp_len.size()) $display("FAIL clr_done_count got %0d want %0d", obs_len.size(), exp_len.size()); else n_pass++;
      for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
         n_tot++;
         if (obs_len[i] !== exp_len[i] || obs_err[i] !== exp_err[i] || obs_cyc[i] != exp_cyc[i])
            $display("FAIL clr_pkt%0d len/err/cyc got %0d/%0d/%0d want %0d/%0d/%0d", i, obs_len[i], obs_err[i], obs_cyc[i], exp_len[i], exp_err[i], exp_cyc[i]);
         else n_pass++;
      end
      obs_len.delete(); obs_err.delete(); obs_cyc.delete(); exp_len.delete(); exp_err.delete(); exp_cyc.delete();
      n_tot++; if ((pkt_cnt | beat_cnt | byte_cnt | err_size_cnt | err_keep_cnt) !== 32'd0) $display("FAIL clr_counters got %0d/%0d/%0d/%0d/%0d want 0", pkt_cnt, beat_cnt, byte_cnt, err_size_cnt, err_keep_cnt); else n_pass++;
      n_tot++; if (err_sticky !== m_sticky) $display("FAIL clr_err_sticky got %b want %b", err_sticky, m_sticky); else n_pass++;
      add_beat('1, 16'd70); add_beat(64'h3F, 16'd70); send_pkt();
      idle(3);
      obs_len.delete(); obs_err.delete(); obs_cyc.delete(); exp_len.delete(); exp_err.delete(); exp_cyc.delete();
      n_tot++; if (beat_cnt !== m_beat || byte_cnt !== m_byte) $display("FAIL clr_resume beat/byte got %0d/%0d want %0d/%0d", beat_cnt, byte_cnt, m_beat, m_byte); else n_pass++;
   endtask

   task automatic test_reset_mid_packet();
      int c;
      bp_enable = 1'b0;
      idle(1);
      send_beat('1, 16'd128, 1'b0, c);
      s_axis_tvalid = 1'b0;
      #1;
      axis_rstn = 1'b0;
      #1;
      n_tot++; if (s_axis_tready !== 1'b0 || pkt_done !== 1'b0) $display("FAIL midrst_ready_done got %b%b want 00", s_axis_tready, pkt_done); else n_pass++;
      n_tot++; if (pkt_len !== 16'd0 || beat_cnt !== 32'd0 || byte_cnt !== 32'd0) $display("FAIL midrst_outputs len/beat/byte got %0d/%0d/%0d want 0", pkt_len, beat_cnt, byte_cnt); else n_pass++;
      m_pkt = 0; m_beat = 0; m_byte = 0; m_esize = 0; m_ekeep = 0; m_sticky = 0;
      repeat (2) @(negedge axis_clk);
      axis_rstn = 1'b1;
      rst_cyc = cyc;
      @(posedge axis_clk); #1;
      add_beat('1, 16'd100); add_beat(64'h0000_000F_FFFF_FFFF, 16'd100); send_pkt();
      idle(3);
      n_tot++; if (obs_len.size() != exp_len.size()) $display("FAIL midrst_done_count got %0d want %0d", obs_len.size(), exp_len.size()); else n_pass++;
      for (int i = 0; i < exp_len.size() && i < obs_len.size(); i++) begin
         n_tot++;
         if (obs_len[i] !== exp_len[i] || obs_err[i] !== exp_err[i] || obs_cyc[i] != exp_cyc[i])
            $display("FAIL midrst_pkt%0d len/err/cyc got %0d/%0d/%0d want %0d/%0d/%0d", i, obs_len[i], obs_err[i], obs_cyc[i], exp_len[i], exp_err[i], exp_cyc[i]);
         else n_pass++;
      end
      obs_len.delete(); obs_err.delete(); obs_cyc.delete(); exp_len.delete(); exp_err.delete(); exp_cyc.delete();
      n_tot++; if (pkt_cnt !== m_pkt || beat_cnt !== m_beat || byte_cnt !== m_byte) $display("FAIL midrst_counters got %0d/%0d/%0d want %0d/%0d/%0d", pkt_cnt, beat_cnt, byte_cnt, m_pkt, m_beat, m_byte); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_random();
      test_stat_clear();
      test_reset_mid_packet();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
